peripheral_uart_tx_wb: RTL and testbench
========================================

# peripheral_uart_tx_wb

Serial transmitter for the MPSoC UART WishBone peripheral. It is the read side of the transmit FIFO: it pops bytes from the FIFO's asynchronous-read storage and serializes each one onto the TX line. Frame format is set by the line-control register: 5–8 data bits, optional odd/even/stick parity, and 1, 1.5 or 2 stop bits. It also supports a forced break condition. Bit timing comes from the 16x baud enable that the divisor logic produces.

## Interface
- DATA_WIDTH, 8, width of a FIFO word and the maximum data bits per frame
- clk  input  1  system clock; every flop is clocked on its rising edge
- rst_n  input  1  reset, asynchronous, active-low
- enable  input  1  16x baud tick; one-clk pulse, 16 ticks per bit
- lcr  input  8  line control: [1:0] word length (00=5 … 11=8), [2] extra stop, [3] parity enable, [4] even parity, [5] stick parity, [6] break, [7] unused
- fifo_data  input  DATA_WIDTH  word at the FIFO read pointer; valid combinationally (async read)
- fifo_empty  input  1  FIFO holds no word
- fifo_pop  output  1  one-clk registered pulse; FIFO advances its read pointer
- stx_o  output  1  serial TX line, idle high
- tx_busy  output  1  high from POP through the final stop tick
- tstate  output  3  current state encoding, for status and debug

## Operation
- States and encoding: IDLE=0, POP=1, START=2, DATA=3, PARITY=4, STOP=5.
- Tick counter: 5 bits, counts `enable` pulses within the current bit. Bit counter: 3 bits, counts data bits.
- IDLE
  - stx_o=1.
  - On a clk with enable=1 and fifo_empty=0: go to POP.
- POP
  - Lasts exactly one clk, independent of enable; fifo_pop=1.
  - shift_reg captures fifo_data.
  - lcr is sampled into an internal frame register. lcr changes have no effect mid-frame, except break.
  - Go to START; tick and bit counters cleared.
- START: stx_o=0 for 16 enables, then go to DATA.
- DATA
  - stx_o=shift_reg[0] (LSB first); shift right after every 16 enables.
  - After wordlen bits (wordlen=5+lcr[1:0]): go to PARITY if lcr[3]=1, else STOP.
- PARITY: held for 16 enables. The bit is:
  - stick (lcr[5]=1): ~lcr[4]
  - even (lcr[4]=1): XOR of the data bits
  - odd: XNOR of the data bits
  - Only the wordlen low bits enter the calculation.
- STOP: stx_o=1. Duration:
  - lcr[2]=0: 16 enables
  - lcr[2]=1 and wordlen=5: 24 enables
  - lcr[2]=1 otherwise: 32 enables
  - Then go to IDLE.
- Break: while live lcr[6]=1, stx_o is forced to 0 in every state. The state machine keeps running, so the frame in flight is consumed and the FIFO keeps draining.
- tx_busy=1 in every state except IDLE.

## Timing
- Reset values: stx_o=1, fifo_pop=0, tx_busy=0, tstate=IDLE, counters=0, shift_reg=0.
- Reset may assert at any time, including mid-frame. On reset the frame is abandoned, stx_o returns to 1 immediately (asynchronously), and no pop is issued.
- Start latency: the IDLE→POP decision occurs on an enable clk. POP occupies the next clk, and stx_o falls on the clk after POP.
- Frame length in enables: 16 × (1 + wordlen + parity) + stop duration.
- Back-to-back frames:
  - The last STOP enable returns the block to IDLE with no pop in that clk.
  - The next enable with fifo_empty=0 starts POP.
  - Idle gap between frames is exactly one enable period.
- fifo_empty is sampled only in IDLE. fifo_data is sampled only in POP.
- fifo_pop never asserts while fifo_empty=1 and never lasts longer than one clk.
- If enable and the last STOP tick coincide while fifo_empty=0, the pop waits for the next enable.

## Test plan
- 8N1 (lcr=0x03), FIFO holds 0xA5, enable every 4 clk.
  - Expect a single fifo_pop pulse.
  - stx_o sequence is 0 | 1,0,1,0,0,1,0,1 | 1, each bit 64 clk.
  - tx_busy drops after 160 enables.
- 7E1 (lcr=0x1A) with 0x41 -> data 1,0,0,0,0,0,1, then parity 0; the same byte with 7O1 (lcr=0x0A) -> parity 1. Stick-even (lcr=0x3A) -> parity 0.
- 5-bit with 2-stop flag (lcr=0x04), byte 0x1F -> five 1s after the start bit, then a stop of exactly 24 enables.
- FIFO holds 0x55 and 0xAA, 8N1.
  - Expect two pops, separated by 10 bit times plus one enable.
  - Each frame's bits must be correct.
  - Once the FIFO is empty, no third pop, and stx_o stays 1.
- lcr[6] asserted mid-DATA, then deasserted -> stx_o=0 for the whole break window and the frame still completes. fifo_pop for the next byte occurs on schedule.
- rst_n pulled low mid-DATA -> stx_o=1, tstate=0, tx_busy=0 immediately. After release with fifo_empty=1, no activity.

Source files
------------

// File: rtl/peripheral_uart_tx_wb_if.sv
// Read-side link between the UART transmit FIFO and the serializer.
// fifo_data is valid combinationally whenever fifo_empty=0; one fifo_pop clk consumes that word.
interface peripheral_uart_tx_wb_if #(
  parameter int DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] fifo_data;
  logic                  fifo_empty;
  logic                  fifo_pop;

  modport master (
    output fifo_pop,
    input  fifo_data,
    input  fifo_empty
  );

  modport slave (
    input  fifo_pop,
    output fifo_data,
    output fifo_empty
  );
endinterface

// File: rtl/peripheral_uart_tx_wb.sv
// UART transmit serializer: pops a FIFO word and shifts it out as a
// start/data/parity/stop frame timed by a 16x baud enable.
module peripheral_uart_tx_wb #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   enable,
  input  logic [7:0]             lcr,
  peripheral_uart_tx_wb_if.master fifo,
  output logic                   stx_o,
  output logic                   tx_busy,
  output logic [2:0]             tstate
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    POP    = 3'd1,
    START  = 3'd2,
    DATA   = 3'd3,
    PARITY = 3'd4,
    STOP   = 3'd5
  } state_t;

  state_t                state, state_next;
  logic [4:0]            tick_cnt;
  logic [2:0]            bit_cnt;
  logic [DATA_WIDTH-1:0] shift_reg;
  logic [1:0]            frame_wl;
  logic                  frame_stop2;
  logic                  frame_par_en;
  logic                  par_bit;

  logic [3:0]            word_len;
  logic                  data_xor;
  logic                  par_calc;
  logic [2:0]            last_bit;
  logic [4:0]            stop_last;
  logic [4:0]            tick_last;
  logic                  tick_end;
  logic                  stx_line;
  logic                  unused_bits;

  assign unused_bits = lcr[7];

  // Parity is computed from the live word at POP, masked to the word length.
  assign word_len = 4'd5 + {2'b00, lcr[1:0]};
  always_comb begin
    data_xor = 1'b0;
    for (int i = 0; i < DATA_WIDTH; i++) begin
      if (i < int'(word_len)) data_xor = data_xor ^ fifo.fifo_data[i];
    end
  end
  assign par_calc = lcr[5] ? ~lcr[4] : (lcr[4] ? data_xor : ~data_xor);

  assign last_bit  = 3'd4 + {1'b0, frame_wl};
  assign stop_last = !frame_stop2 ? 5'd15 : ((frame_wl == 2'd0) ? 5'd23 : 5'd31);
  assign tick_last = (state == STOP) ? stop_last : 5'd15;
  assign tick_end  = enable && (tick_cnt == tick_last);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (enable && !fifo.fifo_empty) state_next = POP;
      POP:     state_next = START;
      START:   if (tick_end) state_next = DATA;
      DATA:    if (tick_end && (bit_cnt == last_bit))
                 state_next = frame_par_en ? PARITY : STOP;
      PARITY:  if (tick_end) state_next = STOP;
      STOP:    if (tick_end) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Frame datapath: captures word and frame format at POP, then counts ticks and bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_cnt     <= 5'd0;
      bit_cnt      <= 3'd0;
      shift_reg    <= '0;
      frame_wl     <= 2'd0;
      frame_stop2  <= 1'b0;
      frame_par_en <= 1'b0;
      par_bit      <= 1'b0;
    end else if (state == POP) begin
      tick_cnt     <= 5'd0;
      bit_cnt      <= 3'd0;
      shift_reg    <= fifo.fifo_data;
      frame_wl     <= lcr[1:0];
      frame_stop2  <= lcr[2];
      frame_par_en <= lcr[3];
      par_bit      <= par_calc;
    end else if (enable && (state != IDLE)) begin
      if (tick_end) begin
        tick_cnt <= 5'd0;
        if (state == DATA) begin
          shift_reg <= {1'b0, shift_reg[DATA_WIDTH-1:1]};
          bit_cnt   <= bit_cnt + 3'd1;
        end
      end else begin
        tick_cnt <= tick_cnt + 5'd1;
      end
    end
  end

  always_comb begin
    stx_line = 1'b1;
    case (state)
      START:   stx_line = 1'b0;
      DATA:    stx_line = shift_reg[0];
      PARITY:  stx_line = par_bit;
      default: stx_line = 1'b1;
    endcase
    // Break uses the live lcr so it takes effect immediately in any state.
    stx_o         = lcr[6] ? 1'b0 : stx_line;
    fifo.fifo_pop = (state == POP);
    tx_busy       = (state != IDLE);
    tstate        = state;
  end

endmodule

// File: tb/tb_peripheral_uart_tx_wb.sv
// Directed bench for peripheral_uart_tx_wb: frame formats, back-to-back frames,
// break and asynchronous reset, with an enable pulse every 4 clks.
module tb_peripheral_uart_tx_wb;

  logic       clk;
  logic       rst_n;
  logic       enable;
  logic [7:0] lcr;
  logic       stx_o;
  logic       tx_busy;
  logic [2:0] tstate;

  peripheral_uart_tx_wb_if #(.DATA_WIDTH(8)) fifo_bus ();

  peripheral_uart_tx_wb #(.DATA_WIDTH(8)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .enable  (enable),
    .lcr     (lcr),
    .fifo    (fifo_bus.master),
    .stx_o   (stx_o),
    .tx_busy (tx_busy),
    .tstate  (tstate)
  );

  int         test_cnt = 0;
  int         fail_cnt = 0;
  int         cyc = 0;
  int         pop_cnt = 0;
  int         bad_pop = 0;
  int         busy_cnt = 0;
  int         div = 0;
  logic [7:0] fifo_q[$];
  int         pop_t[$];
  logic [0:0] tx_q[$];
  logic [0:0] exp_q[$];

  // clock / reset block
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // 16x baud enable: high for one full clk out of every four
  initial begin
    enable = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      div = (div + 1) % 4;
      enable = (div == 0);
    end
  end

  // FIFO model: word at head is visible combinationally, popped at the clk edge ending a pop cycle
  initial begin
    logic p, prev_p;
    prev_p = 1'b0;
    fifo_bus.fifo_empty = 1'b1;
    fifo_bus.fifo_data  = 8'h00;
    forever begin
      @(negedge clk);
      p = fifo_bus.fifo_pop;
      if (p) begin
        pop_cnt++;
        pop_t.push_back(cyc);
        if (fifo_q.size() == 0 || prev_p) bad_pop++;
      end
      prev_p = p;
      @(posedge clk);
      #2;
      if (p && fifo_q.size() > 0) void'(fifo_q.pop_front());
      fifo_bus.fifo_empty = (fifo_q.size() == 0);
      fifo_bus.fifo_data  = (fifo_q.size() > 0) ? fifo_q[0] : 8'h00;
    end
  end

  // line recorder: one sample of stx_o per enable while a frame is in flight
  initial forever begin
    @(negedge clk);
    if (enable && tstate != 3'd0) begin
      tx_q.push_back(stx_o);
      if (tx_busy) busy_cnt++;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    test_cnt++;
    assert (obs === exp_v) else begin
      fail_cnt++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic add_bits(input logic v, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(v);
  endtask

  // par: -1 = no parity bit, otherwise the hand-computed parity value
  task automatic add_frame(input logic [7:0] d, input int wl, input int par, input int stop_n);
    add_bits(1'b0, 16);
    for (int i = 0; i < wl; i++) add_bits(d[i], 16);
    if (par >= 0) add_bits(par[0], 16);
    add_bits(1'b1, stop_n);
  endtask

  task automatic check_frame(input string tag);
    int mism;
    int n;
    mism = 0;
    n = (tx_q.size() < exp_q.size()) ? tx_q.size() : exp_q.size();
    check({tag, "_len"}, tx_q.size(), exp_q.size());
    for (int i = 0; i < n; i++) if (tx_q[i] !== exp_q[i]) mism++;
    check({tag, "_bits"}, mism, 0);
  endtask

  task automatic clear_rec();
    tx_q.delete();
    exp_q.delete();
    pop_t.delete();
    busy_cnt = 0;
    pop_cnt  = 0;
    bad_pop  = 0;
  endtask

  task automatic wait_frames(input int n, input string tag);
    int budget;
    for (int k = 0; k < n; k++) begin
      budget = 0;
      while (!tx_busy && budget < 4000) begin step(); budget++; end
      while (tx_busy && budget < 4000) begin step(); budget++; end
      check({tag, "_done"}, (budget < 4000), 1'b1);
    end
  endtask

  task automatic wait_samples(input int n);
    int budget;
    budget = 0;
    while (tx_q.size() < n && budget < 4000) begin step(); budget++; end
    check("sample_wait", (budget < 4000), 1'b1);
  endtask

  task automatic run_one(input logic [7:0] l, input logic [7:0] d, input string tag);
    clear_rec();
    lcr = l;
    fifo_q.push_back(d);
    wait_frames(1, tag);
    repeat (8) step();
  endtask

  initial begin
    int stx_min;
    rst_n = 1'b0;
    lcr   = 8'h03;
    #3;
    check("rst_stx", stx_o, 1'b1);
    check("rst_pop", fifo_bus.fifo_pop, 1'b0);
    check("rst_busy", tx_busy, 1'b0);
    check("rst_state", tstate, 3'd0);
    repeat (3) step();
    rst_n = 1'b1;
    repeat (8) step();

    // 8N1, 0xA5
    run_one(8'h03, 8'hA5, "8n1");
    add_frame(8'hA5, 8, -1, 16);
    check_frame("8n1");
    check("8n1_pops", pop_cnt, 1);
    check("8n1_busy_en", busy_cnt, 160);
    check("8n1_bad_pop", bad_pop, 0);

    // parity variants on 0x41: bits 1,0,0,0,0,0,1
    run_one(8'h1A, 8'h41, "7e1");
    add_frame(8'h41, 7, 0, 16);
    check_frame("7e1");
    run_one(8'h0A, 8'h41, "7o1");
    add_frame(8'h41, 7, 1, 16);
    check_frame("7o1");
    run_one(8'h3A, 8'h41, "stick");
    add_frame(8'h41, 7, 0, 16);
    check_frame("stick");
    // bit 7 lies outside a 7-bit word and must not affect parity
    run_one(8'h1A, 8'hC1, "7e1_mask");
    add_frame(8'hC1, 7, 0, 16);
    check_frame("7e1_mask");

    // 5 bits, extra stop flag -> 24-enable stop
    run_one(8'h04, 8'h1F, "5n15");
    add_frame(8'h1F, 5, -1, 24);
    check_frame("5n15");
    check("5n15_busy_en", busy_cnt, 120);

    // back-to-back 0x55, 0xAA
    clear_rec();
    lcr = 8'h03;
    fifo_q.push_back(8'h55);
    fifo_q.push_back(8'hAA);
    wait_frames(2, "b2b");
    stx_min = 1;
    for (int i = 0; i < 300; i++) begin
      step();
      if (stx_o !== 1'b1) stx_min = 0;
    end
    add_frame(8'h55, 8, -1, 16);
    add_frame(8'hAA, 8, -1, 16);
    check_frame("b2b");
    check("b2b_pops", pop_cnt, 2);
    check("b2b_sep", (pop_t.size() == 2) ? (pop_t[1] - pop_t[0]) : 0, 644);
    check("b2b_idle_line", stx_min, 1);
    check("b2b_bad_pop", bad_pop, 0);

    // break during DATA of 0xFF, next byte 0x81 follows
    clear_rec();
    lcr = 8'h03;
    fifo_q.push_back(8'hFF);
    fifo_q.push_back(8'h81);
    wait_samples(40);
    lcr = 8'h43;
    wait_samples(72);
    lcr = 8'h03;
    wait_frames(2, "brk");
    repeat (8) step();
    add_frame(8'hFF, 8, -1, 16);
    add_frame(8'h81, 8, -1, 16);
    for (int i = 40; i < 72; i++) exp_q[i] = 1'b0;
    check_frame("brk");
    check("brk_pops", pop_cnt, 2);
    check("brk_sep", (pop_t.size() == 2) ? (pop_t[1] - pop_t[0]) : 0, 644);

    // asynchronous reset during DATA of 0x00
    clear_rec();
    lcr = 8'h03;
    fifo_q.push_back(8'h00);
    wait_samples(40);
    check("pre_rst_stx", stx_o, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_stx", stx_o, 1'b1);
    check("arst_state", tstate, 3'd0);
    check("arst_busy", tx_busy, 1'b0);
    check("arst_pop", fifo_bus.fifo_pop, 1'b0);
    repeat (3) step();
    rst_n = 1'b1;
    stx_min = 1;
    for (int i = 0; i < 200; i++) begin
      step();
      if (stx_o !== 1'b1 || tstate !== 3'd0) stx_min = 0;
    end
    check("post_rst_quiet", stx_min, 1);
    check("post_rst_pops", pop_cnt, 1);
    check("post_rst_bad_pop", bad_pop, 0);

    $display("[TB] %0d tests run, %0d failed", test_cnt, fail_cnt);
    $finish;
  end

endmodule
